// File: rtl/jogo_pkg.sv
// jogo_pkg: shared definitions for the memory-game play detector.
//   - estado_t   : 4-bit FSM state codes (also exported on db_estado)
//   - defaults   : switch-bank width and debounce sample count
//   - is_one_hot : helper used to validate a stable press
package jogo_pkg;

  localparam int N_CHAVES_PADRAO        = 4;
  localparam int DEBOUNCE_CICLOS_PADRAO = 3;

  typedef enum logic [3:0] {
    ESPERA   = 4'd0,
    FILTRA   = 4'd1,
    REGISTRA = 4'd2,
    SOLTA    = 4'd3
  } estado_t;

  // Exactly one bit set; callers zero-extend their vector to 32 bits.
  function automatic logic is_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchroniser for asynchronous inputs.
// Ports:
//   clock  in            system clock
//   reset  in            synchronous, active-high; clears both stages
//   d      in  [LARGURA] asynchronous input vector
//   q      out [LARGURA] input delayed by two clock edges
module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] estagio1;

  always_ff @(posedge clock) begin
    if (reset) begin
      estagio1 <= '0;
      q        <= '0;
    end else begin
      estagio1 <= d;
      q        <= estagio1;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// detector_jogada: conditions the raw switch bank of the memory game and
// turns one stable, one-hot press into a single-cycle strobe plus a held
// play value.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ESPERA   | idle; waits for habilita and a nonzero synchronised press
// FILTRA   | debounce: same nonzero sample DEBOUNCE_CICLOS times
// REGISTRA | one cycle; jogada_feita or jogada_invalida is high
// SOLTA    | waits for DEBOUNCE_CICLOS consecutive all-zero samples
//
// Ports:
//   clock           in   system clock
//   reset           in   synchronous, active-high, highest priority
//   habilita        in   play accepted only while in ESPERA
//   limpa           in   synchronous clear of jogada
//   chaves          in   [N_CHAVES] raw asynchronous switches
//   jogada          out  [N_CHAVES] last valid one-hot play
//   jogada_feita    out  1-cycle strobe, valid play registered
//   jogada_invalida out  1-cycle strobe, stable press was not one-hot
//   tem_jogada      out  synchronised switches nonzero
//   db_estado       out  [4] current state code
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int N_CHAVES        = N_CHAVES_PADRAO,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic                limpa,
  input  logic [N_CHAVES-1:0] chaves,
  output logic [N_CHAVES-1:0] jogada,
  output logic                jogada_feita,
  output logic                jogada_invalida,
  output logic                tem_jogada,
  output logic [3:0]          db_estado
);

  localparam logic [3:0] CONT_FIM = 4'(DEBOUNCE_CICLOS - 1);

  logic [N_CHAVES-1:0] chaves_s;
  logic [N_CHAVES-1:0] amostra;
  logic [3:0]          cont;
  estado_t             estado;

  sincronizador_2ff #(
    .LARGURA(N_CHAVES)
  ) u_sinc (
    .clock(clock),
    .reset(reset),
    .d    (chaves),
    .q    (chaves_s)
  );

  // chaves_s is a flop output, so no raw-input path reaches the outputs.
  assign tem_jogada = |chaves_s;
  assign db_estado  = estado;

  // The strobes are registered on the FILTRA->REGISTRA edge, so they are
  // high exactly while estado == REGISTRA (Moore timing, no decode glitch).
  always_ff @(posedge clock) begin
    if (reset) begin
      estado          <= ESPERA;
      amostra         <= '0;
      cont            <= '0;
      jogada          <= '0;
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
    end else begin
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;

      // Placed before the case so a coincident valid-play write wins.
      if (limpa) jogada <= '0;

      case (estado)
        ESPERA: begin
          if (habilita && (chaves_s != '0)) begin
            estado  <= FILTRA;
            amostra <= chaves_s;
            cont    <= '0;
          end
        end

        FILTRA: begin
          if (chaves_s == '0) begin
            estado <= ESPERA;
          end else if (chaves_s != amostra) begin
            amostra <= chaves_s;
            cont    <= '0;
          end else if (cont == CONT_FIM) begin
            estado <= REGISTRA;
            if (is_one_hot(32'(amostra))) begin
              jogada       <= amostra;
              jogada_feita <= 1'b1;
            end else begin
              jogada_invalida <= 1'b1;
            end
          end else begin
            cont <= cont + 4'd1;
          end
        end

        REGISTRA: begin
          estado <= SOLTA;
          cont   <= '0;
        end

        SOLTA: begin
          if (chaves_s != '0) begin
            cont <= '0;
          end else if (cont == CONT_FIM) begin
            estado <= ESPERA;
          end else begin
            cont <= cont + 4'd1;
          end
        end

        default: estado <= ESPERA;
      endcase
    end
  end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Upstream stage of the memory-game datapath/FSM (circuito_exp4 family).
- Conditions the raw switch bank: 2-FF synchronisation, debounce, one-hot validation.
- Produces a single-cycle "jogada_feita" strobe plus a registered, stable 4-bit jogada value for the comparator/FSM.
- Rejects multi-switch or glitchy presses, and requires full release before the next play is accepted.

Parameters:
N_CHAVES, 4, width of switch bank and jogada register
DEBOUNCE_CICLOS, 3, consecutive identical synchronised samples required (press and release); legal range 1..15

Ports:
clock  in  1  system clock (1 kHz in bench)
reset  in  1  synchronous, active-high; highest priority
habilita  in  1  FSM ready to accept a play; sampled only in ESPERA
limpa  in  1  synchronous clear of jogada register
chaves  in  N_CHAVES  raw asynchronous switch inputs
jogada  out  N_CHAVES  last valid (one-hot) play, held until next valid play/limpa/reset
jogada_feita  out  1  1-cycle strobe: valid play registered
jogada_invalida  out  1  1-cycle strobe: stable press was zero-hot... i.e. not one-hot (≥2 switches)
tem_jogada  out  1  level: synchronised chaves != 0
db_estado  out  4  current state code

Behaviour:
- Reset (sync, active-high), next edge:
  - state=ESPERA, sync flops=0, amostra=0, cont=0.
  - jogada=0, jogada_feita=0, jogada_invalida=0, tem_jogada=0, db_estado=0.
- Synchroniser:
  - chaves_s = chaves delayed by 2 flops.
  - All logic below sees only chaves_s; tem_jogada = |chaves_s (registered path, no raw input).
- States and codes: ESPERA=0, FILTRA=1, REGISTRA=2, SOLTA=3. Other codes are unreachable → ESPERA.
- ESPERA:
  - habilita=1 and chaves_s!=0 → FILTRA, with amostra<=chaves_s, cont<=0.
  - Otherwise stay.
- FILTRA:
  - chaves_s==0 → ESPERA (glitch discarded).
  - chaves_s!=amostra (nonzero) → stay, amostra<=chaves_s, cont<=0.
  - chaves_s==amostra and cont==DEBOUNCE_CICLOS-1 → REGISTRA.
    - If amostra is one-hot: jogada<=amostra and valido<=1.
    - Otherwise valido<=0.
  - chaves_s==amostra otherwise → cont++.
- REGISTRA (exactly 1 cycle):
  - Moore outputs: jogada_feita=valido, jogada_invalida=~valido.
  - Unconditionally → SOLTA, cont<=0.
- SOLTA:
  - chaves_s!=0 → cont<=0, stay.
  - chaves_s==0 and cont==DEBOUNCE_CICLOS-1 → ESPERA.
  - Otherwise cont++.
  - A held press never produces a second strobe.
- Latency: new stable chaves sampled at edge E0 → jogada_feita high in the cycle after edge E(DEBOUNCE_CICLOS+2). With the default that is after E5. jogada is updated on the same edge the strobe rises.
- habilita is ignored outside ESPERA. Deassertion mid-filter does not abort.
- limpa:
  - Sets jogada<=0 in any state.
  - If it coincides with the REGISTRA-entry write, the write wins (jogada = new value).
- Reset mid-operation (any state) → ESPERA next edge. No strobe is emitted.
- cont width is 4 bits, and it never wraps (it is bounded by DEBOUNCE_CICLOS-1).
- No combinational path from chaves to any output.

Decomposition:
- Shared package/header jogo_pkg:
  - state codes ESPERA/FILTRA/REGISTRA/SOLTA (4-bit).
  - N_CHAVES default.
  - DEBOUNCE_CICLOS default.
- Sub-module sincronizador_2ff (parameterised width, sync reset to 0), instantiated once for chaves.
- FSM, counter, amostra/jogada registers live in detector_jogada.

Test Plan:
1. Reset held 1 cycle, habilita=1, chaves=0001 for 10 cycles then 0000 → jogada_feita single pulse 5 edges after first sampling; jogada=0001; db_estado 0→1→2→3→0; jogada_invalida stays 0.
2. chaves=0001 for 2 cycles then 0000 (shorter than debounce+sync) → no strobe, state returns to 0, jogada unchanged.
3. chaves=0101 for 10 cycles → jogada_invalida single pulse, jogada_feita=0, jogada keeps previous value (0001).
4. chaves=0010 held 30 cycles, with 1-cycle bounce to 0000 during release → exactly one jogada_feita, jogada=0010; return to ESPERA only after DEBOUNCE_CICLOS zero samples.
5. habilita=0, chaves=1000 for 10 cycles → no strobe, state stays 0. Then habilita=1 with chaves still 1000 → strobe, jogada=1000.
6. Reset asserted while in FILTRA with chaves=0100 → next edge state=0, jogada=0, no strobes. Also limpa=1 in ESPERA → jogada=0000 next edge.
